// File: rtl/vend_panel_arbiter.sv
// vend_panel_arbiter: shares one vending_machine core between two customer
// panels and a service reload port. One requester owns the core per session.
// Owner inputs are forwarded with one cycle of lag. Core status is routed
// back to the owning panel combinationally. A drain gap separates sessions,
// and an inactivity timeout reclaims the core from an abandoned session.
module vend_panel_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int DRAIN_CYC   = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] card_in_i,
  input  logic [1:0] key_press_i,
  input  logic [7:0] item_code_i,
  input  logic [1:0] valid_tran_i,
  input  logic [1:0] door_open_i,
  input  logic       reload_req_i,
  output logic [1:0] grant_o,
  output logic       reload_ack_o,
  output logic [1:0] timeout_o,
  output logic [1:0] p_vend_o,
  output logic [1:0] p_invalid_sel_o,
  output logic [1:0] p_failed_tran_o,
  output logic [5:0] p_cost_o,
  output logic       m_card_in_o,
  output logic       m_key_press_o,
  output logic [3:0] m_item_code_o,
  output logic       m_valid_tran_o,
  output logic       m_door_open_o,
  output logic       m_reload_o,
  input  logic       m_vend_i,
  input  logic       m_invalid_sel_i,
  input  logic       m_failed_tran_i,
  input  logic [2:0] m_cost_i
);

  localparam int IDLE_W  = $clog2(TIMEOUT_CYC);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SESSION, S_SERVICE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [1:0]          lock_q, lock_d;
  logic [1:0]          grant_q, grant_d;
  logic                reload_ack_q, reload_ack_d;
  logic [1:0]          timeout_q, timeout_d;
  logic                m_card_q, m_card_d;
  logic                m_key_q, m_key_d;
  logic [3:0]          m_item_q, m_item_d;
  logic                m_valid_q, m_valid_d;
  logic                m_door_q, m_door_d;
  logic                m_reload_q, m_reload_d;

  // Panel selection: the round-robin winner while idle, otherwise the owner.
  logic [1:0] eligible;
  logic       pick_idle;
  logic       pick;
  logic       sel_card, sel_key, sel_valid, sel_door;
  logic [3:0] sel_item;
  logic       activity;

  assign eligible  = card_in_i & ~lock_q;
  assign pick_idle = (eligible == 2'b11) ? ~last_q : eligible[1];
  assign pick      = (state_q == S_IDLE) ? pick_idle : owner_q;
  assign sel_card  = card_in_i[pick];
  assign sel_key   = key_press_i[pick];
  assign sel_valid = valid_tran_i[pick];
  assign sel_door  = door_open_i[pick];
  assign sel_item  = pick ? item_code_i[7:4] : item_code_i[3:0];
  assign activity  = sel_key | sel_valid | sel_door | m_vend_i;

  // State register and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      idle_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      lock_q       <= '0;
      grant_q      <= '0;
      reload_ack_q <= 1'b0;
      timeout_q    <= '0;
      m_card_q     <= 1'b0;
      m_key_q      <= 1'b0;
      m_item_q     <= '0;
      m_valid_q    <= 1'b0;
      m_door_q     <= 1'b0;
      m_reload_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      idle_cnt_q   <= idle_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      lock_q       <= lock_d;
      grant_q      <= grant_d;
      reload_ack_q <= reload_ack_d;
      timeout_q    <= timeout_d;
      m_card_q     <= m_card_d;
      m_key_q      <= m_key_d;
      m_item_q     <= m_item_d;
      m_valid_q    <= m_valid_d;
      m_door_q     <= m_door_d;
      m_reload_q   <= m_reload_d;
    end
  end

  // Next-state and next-output logic; core outputs default low.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    idle_cnt_d   = idle_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    lock_d       = lock_q & card_in_i;
    grant_d      = '0;
    reload_ack_d = 1'b0;
    timeout_d    = '0;
    m_card_d     = 1'b0;
    m_key_d      = 1'b0;
    m_item_d     = '0;
    m_valid_d    = 1'b0;
    m_door_d     = 1'b0;
    m_reload_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (reload_req_i) begin
          state_d      = S_SERVICE;
          reload_ack_d = 1'b1;
          m_reload_d   = 1'b1;
        end else if (|eligible) begin
          state_d    = S_SESSION;
          owner_d    = pick_idle;
          last_d     = pick_idle;
          idle_cnt_d = '0;
          grant_d    = pick_idle ? 2'b10 : 2'b01;
          m_card_d   = sel_card;
          m_key_d    = sel_key;
          m_item_d   = sel_item;
          m_valid_d  = sel_valid;
          m_door_d   = sel_door;
        end
      end
      S_SESSION: begin
        if (!sel_card) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else if (!activity && idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
          timeout_d   = owner_q ? 2'b10 : 2'b01;
          lock_d      = lock_d | timeout_d;
        end else begin
          grant_d    = owner_q ? 2'b10 : 2'b01;
          idle_cnt_d = activity ? '0 : idle_cnt_q + 1'b1;
          m_card_d   = sel_card;
          m_key_d    = sel_key;
          m_item_d   = sel_item;
          m_valid_d  = sel_valid;
          m_door_d   = sel_door;
        end
      end
      S_SERVICE: begin
        if (reload_req_i) begin
          reload_ack_d = 1'b1;
          m_reload_d   = 1'b1;
        end else begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant_o       = grant_q;
  assign reload_ack_o  = reload_ack_q;
  assign timeout_o     = timeout_q;
  assign m_card_in_o   = m_card_q;
  assign m_key_press_o = m_key_q;
  assign m_item_code_o = m_item_q;
  assign m_valid_tran_o = m_valid_q;
  assign m_door_open_o = m_door_q;
  assign m_reload_o    = m_reload_q;

  // Return path: core status reaches only the panel currently granted.
  assign p_vend_o        = grant_q & {2{m_vend_i}};
  assign p_invalid_sel_o = grant_q & {2{m_invalid_sel_i}};
  assign p_failed_tran_o = grant_q & {2{m_failed_tran_i}};
  assign p_cost_o        = {grant_q[1] ? m_cost_i : 3'd0,
                            grant_q[0] ? m_cost_i : 3'd0};

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Self-checking bench for vend_panel_arbiter: a table of directed session
// vectors followed by hand-written timeout, service, and reset sequences.
module tb_vend_panel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] card_in, key_press, valid_tran, door_open;
  logic [7:0] item_code;
  logic       reload_req;
  logic [1:0] grant, timeout, p_vend, p_inv, p_fail;
  logic       reload_ack;
  logic [5:0] p_cost;
  logic       m_card, m_key, m_valid, m_door, m_reload;
  logic [3:0] m_item;
  logic       m_vend, m_inv, m_fail;
  logic [2:0] m_cost;

  int tests_run    = 0;
  int tests_failed = 0;

  vend_panel_arbiter #(.TIMEOUT_CYC(16), .DRAIN_CYC(2)) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .card_in_i       (card_in),
    .key_press_i     (key_press),
    .item_code_i     (item_code),
    .valid_tran_i    (valid_tran),
    .door_open_i     (door_open),
    .reload_req_i    (reload_req),
    .grant_o         (grant),
    .reload_ack_o    (reload_ack),
    .timeout_o       (timeout),
    .p_vend_o        (p_vend),
    .p_invalid_sel_o (p_inv),
    .p_failed_tran_o (p_fail),
    .p_cost_o        (p_cost),
    .m_card_in_o     (m_card),
    .m_key_press_o   (m_key),
    .m_item_code_o   (m_item),
    .m_valid_tran_o  (m_valid),
    .m_door_open_o   (m_door),
    .m_reload_o      (m_reload),
    .m_vend_i        (m_vend),
    .m_invalid_sel_i (m_inv),
    .m_failed_tran_i (m_fail),
    .m_cost_i        (m_cost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] card;
    logic [1:0] key;
    logic [7:0] item;
    logic [1:0] valid;
    logic [1:0] door;
    logic [2:0] ms;    // {vend, invalid_sel, failed_tran} from the core
    logic [2:0] cost;
  } in_t;

  typedef struct packed {
    logic [1:0] grant;
    logic       ack;
    logic [1:0] tmo;
    logic       mcard;
    logic       mkey;
    logic [3:0] mitem;
    logic       mvalid;
    logic       mdoor;
    logic       mreload;
    logic [1:0] pv;
    logic [1:0] pi;
    logic [1:0] pf;
    logic [5:0] pcost;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t mk_in(logic [1:0] card, logic [1:0] key, logic [7:0] item,
                                logic [1:0] valid, logic [1:0] door, logic [2:0] ms,
                                logic [2:0] cost);
    in_t s;
    s.card = card; s.key = key; s.item = item; s.valid = valid;
    s.door = door; s.ms = ms; s.cost = cost;
    return s;
  endfunction

  function automatic out_t mk_out(logic [1:0] g, logic mc, logic mk, logic [3:0] mi,
                                  logic mv, logic md, logic [1:0] pv, logic [1:0] pi,
                                  logic [1:0] pf, logic [5:0] pc);
    out_t o;
    o = '0;
    o.grant = g; o.mcard = mc; o.mkey = mk; o.mitem = mi; o.mvalid = mv;
    o.mdoor = md; o.pv = pv; o.pi = pi; o.pf = pf; o.pcost = pc;
    return o;
  endfunction

  function automatic out_t get_outs();
    out_t o;
    o.grant = grant; o.ack = reload_ack; o.tmo = timeout; o.mcard = m_card;
    o.mkey = m_key; o.mitem = m_item; o.mvalid = m_valid; o.mdoor = m_door;
    o.mreload = m_reload; o.pv = p_vend; o.pi = p_inv; o.pf = p_fail;
    o.pcost = p_cost;
    return o;
  endfunction

  task automatic apply(input in_t s);
    card_in = s.card; key_press = s.key; item_code = s.item;
    valid_tran = s.valid; door_open = s.door;
    {m_vend, m_inv, m_fail} = s.ms; m_cost = s.cost;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input in_t s, input out_t e);
    vec_t v;
    v.stim = s; v.exp = e;
    vecs.push_back(v);
  endtask

  localparam out_t ZERO = '0;

  initial begin
    int n;
    bit seen;

    // Both panels tie after reset: panel 0 wins, panel 1 inputs are ignored.
    add(mk_in(2'b11, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), mk_out(2'b01, 1, 0, 4'h0, 0, 0, 2'b00, 2'b00, 2'b00, 6'd0));
    add(mk_in(2'b11, 2'b01, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), mk_out(2'b01, 1, 1, 4'h0, 0, 0, 2'b00, 2'b00, 2'b00, 6'd0));
    add(mk_in(2'b11, 2'b01, 8'h08, 2'b00, 2'b00, 3'b000, 3'd0), mk_out(2'b01, 1, 1, 4'h8, 0, 0, 2'b00, 2'b00, 2'b00, 6'd0));
    add(mk_in(2'b11, 2'b10, 8'h18, 2'b10, 2'b00, 3'b000, 3'd0), mk_out(2'b01, 1, 0, 4'h8, 0, 0, 2'b00, 2'b00, 2'b00, 6'd0));
    add(mk_in(2'b11, 2'b10, 8'h38, 2'b10, 2'b00, 3'b000, 3'd0), mk_out(2'b01, 1, 0, 4'h8, 0, 0, 2'b00, 2'b00, 2'b00, 6'd0));
    add(mk_in(2'b11, 2'b00, 8'h08, 2'b01, 2'b00, 3'b010, 3'd3), mk_out(2'b01, 1, 0, 4'h8, 1, 0, 2'b00, 2'b01, 2'b00, 6'd3));
    add(mk_in(2'b11, 2'b00, 8'h08, 2'b00, 2'b01, 3'b100, 3'd5), mk_out(2'b01, 1, 0, 4'h8, 0, 1, 2'b01, 2'b00, 2'b00, 6'd5));
    add(mk_in(2'b11, 2'b00, 8'h08, 2'b00, 2'b00, 3'b101, 3'd5), mk_out(2'b01, 1, 0, 4'h8, 0, 0, 2'b01, 2'b00, 2'b01, 6'd5));
    // Panel 0 card out: drain for two cycles, then panel 1 is granted.
    add(mk_in(2'b10, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b10, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b10, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b10, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), mk_out(2'b10, 1, 0, 4'h0, 0, 0, 2'b00, 2'b00, 2'b00, 6'd0));
    add(mk_in(2'b10, 2'b10, 8'h30, 2'b00, 2'b00, 3'b100, 3'd6), mk_out(2'b10, 1, 1, 4'h3, 0, 0, 2'b10, 2'b00, 2'b00, 6'd48));
    // Panel 1 leaves, both cards present again: tie goes to panel 0.
    add(mk_in(2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b11, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b11, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b11, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), mk_out(2'b01, 1, 0, 4'h0, 0, 0, 2'b00, 2'b00, 2'b00, 6'd0));
    add(mk_in(2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);
    add(mk_in(2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0), ZERO);

    // Reset state, with requests and core status already active.
    rst_n = 1'b0;
    reload_req = 1'b0;
    apply(mk_in(2'b11, 2'b11, 8'hFF, 2'b11, 2'b11, 3'b111, 3'd7));
    repeat (2) step();
    check("reset_outputs", 32'(get_outs()), 32'(ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    apply('0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].stim);
      step();
      check($sformatf("vec%0d", i), 32'(get_outs()), 32'(vecs[i].exp));
    end

    // Abandoned panel 1 session: timeout 16 edges after the grant edge.
    apply(mk_in(2'b10, 2'b00, 8'h00, 2'b00, 2'b00, 3'b000, 3'd0));
    step();
    check("tmo_grant", 32'(grant), 32'(2'b10));
    n = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      if (timeout != 2'b00) begin
        seen = 1'b1;
        n = c;
      end
    end
    check("tmo_latency", 32'(n), 32'd16);
    check("tmo_pulse", 32'(timeout), 32'(2'b10));
    check("tmo_grant_drop", 32'({grant, m_card}), 32'(3'b000));
    step();
    check("tmo_one_cycle", 32'(timeout), 32'(2'b00));
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("tmo_locked%0d", c), 32'(grant), 32'(2'b00));
    end
    card_in = 2'b00;
    step();
    card_in = 2'b10;
    step();
    check("tmo_regrant", 32'(grant), 32'(2'b10));
    card_in = 2'b00;
    repeat (3) step();

    // Service request during a panel 0 session waits for session and drain.
    card_in = 2'b01;
    step();
    check("svc_sess_grant", 32'(grant), 32'(2'b01));
    reload_req = 1'b1;
    repeat (2) step();
    check("svc_no_preempt", 32'({grant, reload_ack, m_reload}), 32'(4'b0100));
    card_in = 2'b10;
    step();
    check("svc_drain0", 32'({grant, reload_ack, m_reload}), 32'(4'b0000));
    repeat (2) step();
    check("svc_drain_end", 32'({grant, reload_ack, m_reload}), 32'(4'b0000));
    step();
    check("svc_wins", 32'({grant, reload_ack, m_reload, m_card}), 32'(5'b00110));
    step();
    check("svc_hold", 32'({grant, reload_ack, m_reload}), 32'(4'b0011));
    reload_req = 1'b0;
    step();
    check("svc_release", 32'({grant, reload_ack, m_reload}), 32'(4'b0000));
    repeat (3) step();
    check("svc_after_grant", 32'(grant), 32'(2'b10));
    card_in = 2'b00;
    repeat (3) step();

    // Asynchronous reset in the middle of a vending session.
    card_in = 2'b01;
    step();
    {m_vend, m_inv, m_fail} = 3'b100;
    #1;
    check("rst_pre_vend", 32'({grant, m_card, p_vend}), 32'(5'b01101));
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", 32'({grant, m_card, p_vend}), 32'(5'b00000));
    @(negedge clk);
    rst_n = 1'b1;
    {m_vend, m_inv, m_fail} = 3'b000;
    card_in = 2'b10;
    step();
    check("rst_regrant", 32'({grant, m_card}), 32'(3'b101));
    card_in = 2'b00;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vend_panel_arbiter.md
# vend_panel_arbiter

Arbiter that shares one `vending_machine` core between two customer front panels (panel 0, panel 1) and a service reload port. It grants the core to one requester at a time for a whole card session, forwarding that requester's inputs to the core and routing the core's status back. A drain gap after every session returns the core to idle before the next grant. An inactivity timeout reclaims the core from an abandoned session.

## Interface
- `TIMEOUT_CYC`, 16: session cycles with no owner activity before forced release (>=2).
- `DRAIN_CYC`, 2: cycles all core inputs are held low between grants (>=1).
- `CLK`  in  1  single clock, rising edge.
- `RESET_N`  in  1  reset, asynchronous, active-low.
- `CARD_IN`  in  2  per-panel card present; bit i = panel i.
- `KEY_PRESS`  in  2  per-panel key strobe.
- `ITEM_CODE`  in  8  per-panel digit; [3:0] = panel 0, [7:4] = panel 1.
- `VALID_TRAN`  in  2  per-panel transaction approval.
- `DOOR_OPEN`  in  2  per-panel door sensor.
- `RELOAD_REQ`  in  1  service reload request, level.
- `GRANT`  out  2  one-hot (or zero) current panel owner.
- `RELOAD_ACK`  out  1  service owns the core.
- `TIMEOUT`  out  2  one-cycle pulse, session of panel i force-released.
- `P_VEND`, `P_INVALID_SEL`, `P_FAILED_TRAN`  out  2 each  core status routed to the owner panel.
- `P_COST`  out  6  [2:0] panel 0, [5:3] panel 1.
- `M_CARD_IN`, `M_KEY_PRESS`, `M_VALID_TRAN`, `M_DOOR_OPEN`, `M_RELOAD`  out  1 each  core inputs.
- `M_ITEM_CODE`  out  4  core digit.
- `M_VEND`, `M_INVALID_SEL`, `M_FAILED_TRAN`  in  1 each  core status.
- `M_COST`  in  3  core cost.

## Operation
- States: IDLE, SESSION, SERVICE, DRAIN. Registers: owner, `last` (most recently granted panel), idle counter, drain counter, `lock[1:0]`.
- IDLE: all `M_*` outputs are 0.
  - `RELOAD_REQ`=1 -> SERVICE. Service has priority over panels.
  - Else an eligible panel (`CARD_IN[i]`=1, `lock[i]`=0) -> SESSION, owner=i, `last`=i.
  - Both panels eligible: grant the panel != `last` (round-robin).
- SESSION:
  - Each edge, `M_CARD_IN/KEY_PRESS/ITEM_CODE/VALID_TRAN/DOOR_OPEN` <= the owner's inputs. `M_RELOAD`=0.
  - Activity = owner `KEY_PRESS`|`VALID_TRAN`|`DOOR_OPEN`, or `M_VEND`=1. Activity clears the idle counter; otherwise it increments.
  - Owner `CARD_IN`=0 -> DRAIN. This exit has priority over timeout.
  - Idle counter = `TIMEOUT_CYC`-1 with no activity -> DRAIN, `TIMEOUT[owner]` pulses, `lock[owner]`=1.
  - Non-owner inputs are ignored. `RELOAD_REQ` never preempts a session.
- SERVICE: `M_RELOAD`=1 and `RELOAD_ACK`=1 while `RELOAD_REQ`=1. Panel `M_*` outputs are 0. `RELOAD_REQ`=0 -> DRAIN.
- DRAIN:
  - All `M_*`=0, `GRANT`=0, `RELOAD_ACK`=0 for `DRAIN_CYC` cycles, then IDLE.
  - Requests arriving during DRAIN are evaluated in IDLE.
- Return path, combinational:
  - `P_*[owner]` = `M_*` while `GRANT[owner]`=1.
  - Non-owner bits, and all bits outside SESSION, are 0.
- Lock: `lock[i]` clears on any cycle `CARD_IN[i]`=0. A timed-out panel must remove its card before it can be re-granted.

## Timing
- Reset (async assert): state=IDLE, `last`=1 (panel 0 wins the first tie), counters=0, `lock`=0.
- Reset values of outputs: `GRANT`, `RELOAD_ACK`, `TIMEOUT` and all `M_*` registered outputs are 0. `P_*` are 0 as a consequence.
- Reset deasserts synchronously to `CLK` externally.
- Grant latency: `CARD_IN[i]` sampled high in IDLE at edge N -> `GRANT[i]`=1 and `M_CARD_IN`=1 after edge N.
- Forwarding latency: 1 cycle, owner input -> `M_*`. Return path: 0 cycles.
- Release: owner `CARD_IN` sampled low at edge N -> DRAIN from edge N; `GRANT`=0 and `M_CARD_IN`=0 after N. Next grant no earlier than edge N+`DRAIN_CYC`+1.
- Timeout: with no activity, release occurs `TIMEOUT_CYC` edges after the last activity edge. `TIMEOUT` is high exactly one cycle, coincident with the DRAIN entry.
- Reset mid-session: `GRANT` and `M_*` drop immediately and asynchronously. The core sees `M_CARD_IN`=0.
- `GRANT` and `RELOAD_ACK` are never both high. At most one `GRANT` bit is high.

## Test plan
- Panel 0 session: `CARD_IN[0]`=1, keys 0 then 8, `VALID_TRAN`, `DOOR_OPEN`, card out -> `GRANT`=01 one cycle after the card. `M_ITEM_CODE` follows the digits at 1-cycle lag. `P_VEND[0]` mirrors `M_VEND`, `P_VEND[1]`=0. `GRANT`=00 one cycle after the card is removed.
- Simultaneous cards after reset -> panel 0 granted. On its release with panel 1 still present -> panel 1 granted `DRAIN_CYC`+1 cycles later. Next tie -> panel 0.
- Panel 1 holds the card with no activity -> `TIMEOUT[1]` pulses after 16 idle cycles and `GRANT`=00. Panel 1 is not re-granted until `CARD_IN[1]` toggles 0 then 1.
- `RELOAD_REQ`=1 during a panel 0 session -> `RELOAD_ACK`=0 until the session and drain end, then `M_RELOAD`=1 and `RELOAD_ACK`=1. `RELOAD_REQ` and `CARD_IN[1]` both high in IDLE -> service wins.
- Panel 1 keys 1, 3 and `VALID_TRAN` while panel 0 owns the core -> `M_ITEM_CODE` and `M_VALID_TRAN` carry only panel 0 values. `P_*[1]`=0.
- `RESET_N` low mid-session with `M_VEND`=1 -> `GRANT`, `M_CARD_IN` and `P_VEND` all 0 immediately. After release, the first request is granted normally.
